// File: rtl/score_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// score_pkg: controller state type and sizing helpers for score_tracker. Rev 1.0
// ---------------------------------------------------------------------------
package score_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int mult_width(input int max_mult);
    return $clog2(max_mult + 1);
  endfunction

  // Streak stops growing once the multiplier has reached its ceiling.
  function automatic int streak_max(input int streak_len, input int max_mult);
    return streak_len * (max_mult - 1);
  endfunction

  function automatic int streak_width(input int streak_len, input int max_mult);
    int w;
    w = $clog2(streak_max(streak_len, max_mult) + 1);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int leader_width(input int num_players);
    return (num_players > 1) ? $clog2(num_players) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/score_lane.sv
`default_nettype none
// ---------------------------------------------------------------------------
// score_lane: one player's saturating score, streak and multiplier. Rev 1.0
// ---------------------------------------------------------------------------
module score_lane
  import score_pkg::*;
#(
  parameter int SCORE_W    = 8,
  parameter int STREAK_LEN = 4,
  parameter int MAX_MULT   = 4,
  parameter int MW         = mult_width(MAX_MULT)
) (
  input  logic               clkIn,
  input  logic               reset,
  input  logic               clear,
  input  logic               enable,
  input  logic               hit,
  input  logic               miss,
  output logic [SCORE_W-1:0] score,
  output logic [MW-1:0]      mult
);

  localparam int SMAX = streak_max(STREAK_LEN, MAX_MULT);
  localparam int SW   = streak_width(STREAK_LEN, MAX_MULT);

  logic [SCORE_W-1:0] score_q, score_d;
  logic [SW-1:0]      streak_q, streak_d;
  logic [SCORE_W:0]   sum;

  assign mult  = MW'(int'(streak_q) / STREAK_LEN + 1);
  assign sum   = {1'b0, score_q} + (SCORE_W + 1)'(mult);
  assign score = score_q;

  // A hit takes priority over a simultaneous miss.
  always_comb begin
    score_d  = score_q;
    streak_d = streak_q;
    if (clear) begin
      score_d  = '0;
      streak_d = '0;
    end else if (enable && hit) begin
      score_d = sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
      if (int'(streak_q) < SMAX) begin
        streak_d = streak_q + SW'(1);
      end
    end else if (enable && miss) begin
      streak_d = '0;
    end
  end

  always_ff @(posedge clkIn or negedge reset) begin
    if (!reset) begin
      score_q  <= '0;
      streak_q <= '0;
    end else begin
      score_q  <= score_d;
      streak_q <= streak_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/score_tracker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// score_tracker: round controller, per-player lanes, leader/tie and high score. Rev 1.0
// ---------------------------------------------------------------------------
module score_tracker
  import score_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int SCORE_W     = 8,
  parameter int STREAK_LEN  = 4,
  parameter int MAX_MULT    = 4
) (
  input  logic                                         clkIn,
  input  logic                                         reset,
  input  logic                                         game_active,
  input  logic                                         timer_expired,
  input  logic [NUM_PLAYERS-1:0]                       hit,
  input  logic [NUM_PLAYERS-1:0]                       miss,
  output logic [NUM_PLAYERS*SCORE_W-1:0]               score,
  output logic [NUM_PLAYERS*mult_width(MAX_MULT)-1:0]  mult,
  output logic [SCORE_W-1:0]                           high_score,
  output logic                                         new_high,
  output logic [leader_width(NUM_PLAYERS)-1:0]         leader,
  output logic                                         tie
);

  localparam int MW = mult_width(MAX_MULT);
  localparam int LW = leader_width(NUM_PLAYERS);

  state_e                       state_q, state_d;
  logic                         clear, enable;
  logic [SCORE_W-1:0]           high_q, high_d;
  logic                         new_high_q, new_high_d;
  logic [NUM_PLAYERS*SCORE_W-1:0] scores;
  logic [SCORE_W-1:0]           max_score;
  logic [LW-1:0]                lead_idx;

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_lane
    score_lane #(
      .SCORE_W   (SCORE_W),
      .STREAK_LEN(STREAK_LEN),
      .MAX_MULT  (MAX_MULT),
      .MW        (MW)
    ) u_lane (
      .clkIn (clkIn),
      .reset (reset),
      .clear (clear),
      .enable(enable),
      .hit   (hit[g]),
      .miss  (miss[g]),
      .score (scores[g*SCORE_W +: SCORE_W]),
      .mult  (mult[g*MW +: MW])
    );
  end

  // Strict '>' keeps the lowest index as leader among equal maxima.
  always_comb begin
    max_score = scores[SCORE_W-1:0];
    lead_idx  = '0;
    tie       = 1'b0;
    for (int i = 1; i < NUM_PLAYERS; i++) begin
      if (scores[i*SCORE_W +: SCORE_W] > max_score) begin
        max_score = scores[i*SCORE_W +: SCORE_W];
        lead_idx  = LW'(i);
        tie       = 1'b0;
      end else if (scores[i*SCORE_W +: SCORE_W] == max_score) begin
        tie = 1'b1;
      end
    end
  end

  // Lanes are enabled only on RUN cycles that stay in RUN.
  always_comb begin
    state_d    = state_q;
    clear      = 1'b0;
    enable     = 1'b0;
    high_d     = high_q;
    new_high_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (game_active) begin
          state_d = RUN;
          clear   = 1'b1;
        end
      end
      RUN: begin
        if (timer_expired || !game_active) begin
          state_d = DONE;
          if (max_score > high_q) begin
            high_d     = max_score;
            new_high_d = 1'b1;
          end
        end else begin
          enable = 1'b1;
        end
      end
      DONE: begin
        if (game_active && !timer_expired) begin
          state_d = RUN;
          clear   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clkIn or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      high_q     <= '0;
      new_high_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      high_q     <= high_d;
      new_high_q <= new_high_d;
    end
  end

  assign score      = scores;
  assign high_score = high_q;
  assign new_high   = new_high_q;
  assign leader     = lead_idx;

endmodule
`default_nettype wire

// File: tb/tb_score_tracker.sv
`default_nettype none
// tb_score_tracker: directed vector table, hand sequences and a randomized run
// compared against a behavioural model of the scoring rules.
module tb_score_tracker;

  localparam int SL = 4;
  localparam int MM = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        ga, te;
  logic [1:0]  hit, miss;
  logic [15:0] score8;
  logic [7:0]  score4;
  logic [5:0]  mult8, mult4;
  logic [7:0]  hs8;
  logic [3:0]  hs4;
  logic        nh8, nh4, ld8, ld4, tie8, tie4;

  always #5 clk = ~clk;

  score_tracker #(.NUM_PLAYERS(2), .SCORE_W(8), .STREAK_LEN(SL), .MAX_MULT(MM)) u_dut8 (
    .clkIn(clk), .reset(reset), .game_active(ga), .timer_expired(te),
    .hit(hit), .miss(miss), .score(score8), .mult(mult8), .high_score(hs8),
    .new_high(nh8), .leader(ld8), .tie(tie8)
  );

  score_tracker #(.NUM_PLAYERS(2), .SCORE_W(4), .STREAK_LEN(SL), .MAX_MULT(MM)) u_dut4 (
    .clkIn(clk), .reset(reset), .game_active(ga), .timer_expired(te),
    .hit(hit), .miss(miss), .score(score4), .mult(mult4), .high_score(hs4),
    .new_high(nh4), .leader(ld4), .tie(tie4)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int in_round;   // 0 = before first round, 1 = round running, 2 = round over
  int ms8[2], ms4[2], mstk[2];
  int mhs8, mhs4;
  int mnh8, mnh4;

  task automatic model_reset();
    in_round = 0;
    for (int p = 0; p < 2; p++) begin
      ms8[p] = 0; ms4[p] = 0; mstk[p] = 0;
    end
    mhs8 = 0; mhs4 = 0; mnh8 = 0; mnh4 = 0;
  endtask

  task automatic model_step(input logic g, input logic t, input logic [1:0] h, input logic [1:0] m);
    int best8, best4, add;
    bit start;
    mnh8 = 0; mnh4 = 0;
    start = (in_round == 0 && g) || (in_round == 2 && g && !t);
    if (start) begin
      in_round = 1;
      for (int p = 0; p < 2; p++) begin
        ms8[p] = 0; ms4[p] = 0; mstk[p] = 0;
      end
    end else if (in_round == 1) begin
      if (t || !g) begin
        in_round = 2;
        best8 = (ms8[0] > ms8[1]) ? ms8[0] : ms8[1];
        best4 = (ms4[0] > ms4[1]) ? ms4[0] : ms4[1];
        if (best8 > mhs8) begin mhs8 = best8; mnh8 = 1; end
        if (best4 > mhs4) begin mhs4 = best4; mnh4 = 1; end
      end else begin
        for (int p = 0; p < 2; p++) begin
          if (h[p]) begin
            add = 1 + mstk[p] / SL;
            ms8[p] = (ms8[p] + add > 255) ? 255 : ms8[p] + add;
            ms4[p] = (ms4[p] + add > 15) ? 15 : ms4[p] + add;
            if (mstk[p] < SL * (MM - 1)) mstk[p]++;
          end else if (m[p]) begin
            mstk[p] = 0;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    int b8, b4, l8, l4, c8, c4;
    for (int p = 0; p < 2; p++) begin
      check($sformatf("score8[%0d]", p), score8[p*8 +: 8], ms8[p]);
      check($sformatf("score4[%0d]", p), score4[p*4 +: 4], ms4[p]);
      check($sformatf("mult8[%0d]", p), mult8[p*3 +: 3], 1 + mstk[p] / SL);
      check($sformatf("mult4[%0d]", p), mult4[p*3 +: 3], 1 + mstk[p] / SL);
    end
    check("high8", hs8, mhs8);
    check("high4", hs4, mhs4);
    check("new_high8", nh8, mnh8);
    check("new_high4", nh4, mnh4);
    b8 = -1; b4 = -1; l8 = 0; l4 = 0; c8 = 0; c4 = 0;
    for (int p = 0; p < 2; p++) begin
      if (ms8[p] > b8) begin b8 = ms8[p]; l8 = p; end
      if (ms4[p] > b4) begin b4 = ms4[p]; l4 = p; end
    end
    for (int p = 0; p < 2; p++) begin
      if (ms8[p] == b8) c8++;
      if (ms4[p] == b4) c4++;
    end
    check("leader8", ld8, l8);
    check("leader4", ld4, l4);
    check("tie8", tie8, int'(c8 > 1));
    check("tie4", tie4, int'(c4 > 1));
  endtask

  task automatic step(input logic g, input logic t, input logic [1:0] h, input logic [1:0] m);
    ga = g; te = t; hit = h; miss = m;
    @(posedge clk);
    model_step(g, t, h, m);
    #1;
    check_all();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".score8"}, score8, 0);
    check({tag, ".score4"}, score4, 0);
    check({tag, ".mult8"}, mult8, 6'b001_001);
    check({tag, ".mult4"}, mult4, 6'b001_001);
    check({tag, ".high8"}, hs8, 0);
    check({tag, ".high4"}, hs4, 0);
    check({tag, ".new_high"}, nh8, 0);
    check({tag, ".leader"}, ld8, 0);
    check({tag, ".tie"}, tie8, 1);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       g, t;
    logic [1:0] h, m;
    int         rpt, s0, s1, m0, m1, hs, nh, ld, ti;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic g, input logic t, input logic [1:0] h, input logic [1:0] m,
                     input int rpt, input int s0, input int s1, input int m0, input int m1,
                     input int hs, input int nh, input int ld, input int ti);
    vec_t v;
    v.g = g; v.t = t; v.h = h; v.m = m; v.rpt = rpt;
    v.s0 = s0; v.s1 = s1; v.m0 = m0; v.m1 = m1;
    v.hs = hs; v.nh = nh; v.ld = ld; v.ti = ti;
    tbl.push_back(v);
  endtask

  initial begin
    reset = 1'b0; ga = 1'b0; te = 1'b0; hit = '0; miss = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("por");
    @(negedge clk);
    reset = 1'b1;

    //  g  t  hit    miss  rpt  s0  s1 m0 m1  hs nh ld ti
    // round 1 ends 9/5: new high
    add(1, 0, 2'b00, 2'b00, 1,   0,  0, 1, 1,  0, 0, 0, 1);
    add(1, 0, 2'b11, 2'b00, 4,   4,  4, 2, 2,  0, 0, 0, 1);
    add(1, 0, 2'b01, 2'b00, 2,   8,  4, 2, 2,  0, 0, 0, 0);
    add(1, 0, 2'b00, 2'b11, 1,   8,  4, 1, 1,  0, 0, 0, 0);
    add(1, 0, 2'b11, 2'b00, 1,   9,  5, 1, 1,  0, 0, 0, 0);
    add(0, 0, 2'b00, 2'b00, 1,   9,  5, 1, 1,  9, 1, 0, 0);
    add(0, 0, 2'b00, 2'b00, 1,   9,  5, 1, 1,  9, 0, 0, 0);
    // round 2 ends 9/3: equal, no pulse; DONE holds with timer+active together
    add(1, 0, 2'b00, 2'b00, 1,   0,  0, 1, 1,  9, 0, 0, 1);
    add(1, 0, 2'b11, 2'b00, 3,   3,  3, 1, 1,  9, 0, 0, 1);
    add(1, 0, 2'b01, 2'b00, 3,   8,  3, 2, 1,  9, 0, 0, 0);
    add(1, 0, 2'b00, 2'b01, 1,   8,  3, 1, 1,  9, 0, 0, 0);
    add(1, 0, 2'b01, 2'b00, 1,   9,  3, 1, 1,  9, 0, 0, 0);
    add(1, 1, 2'b00, 2'b00, 1,   9,  3, 1, 1,  9, 0, 0, 0);
    add(1, 1, 2'b00, 2'b00, 1,   9,  3, 1, 1,  9, 0, 0, 0);
    // round 3 ends 4/11: new high
    add(1, 0, 2'b00, 2'b00, 1,   0,  0, 1, 1,  9, 0, 0, 1);
    add(1, 0, 2'b11, 2'b00, 4,   4,  4, 2, 2,  9, 0, 0, 1);
    add(1, 0, 2'b10, 2'b00, 3,   4, 10, 2, 2,  9, 0, 1, 0);
    add(1, 0, 2'b00, 2'b10, 1,   4, 10, 2, 1,  9, 0, 1, 0);
    add(1, 0, 2'b10, 2'b00, 1,   4, 11, 2, 1,  9, 0, 1, 0);
    add(0, 0, 2'b00, 2'b00, 1,   4, 11, 2, 1, 11, 1, 1, 0);
    add(0, 0, 2'b00, 2'b00, 1,   4, 11, 2, 1, 11, 0, 1, 0);
    // streak, saturation (narrow instance), miss/priority, boundary cycles
    add(1, 0, 2'b01, 2'b00, 1,   0,  0, 1, 1, 11, 0, 0, 1);
    add(1, 0, 2'b01, 2'b00, 12, 24,  0, 4, 1, 11, 0, 0, 0);
    add(1, 0, 2'b01, 2'b00, 8,  56,  0, 4, 1, 11, 0, 0, 0);
    add(1, 0, 2'b00, 2'b01, 1,  56,  0, 1, 1, 11, 0, 0, 0);
    add(1, 0, 2'b10, 2'b00, 5,  56,  6, 1, 2, 11, 0, 0, 0);
    add(1, 0, 2'b00, 2'b10, 1,  56,  6, 1, 1, 11, 0, 0, 0);
    add(1, 0, 2'b10, 2'b00, 1,  56,  7, 1, 1, 11, 0, 0, 0);
    add(1, 0, 2'b10, 2'b10, 3,  56, 10, 1, 2, 11, 0, 0, 0);
    add(1, 1, 2'b11, 2'b00, 1,  56, 10, 1, 2, 56, 1, 0, 0);
    add(0, 0, 2'b00, 2'b00, 2,  56, 10, 1, 2, 56, 0, 0, 0);
    add(1, 0, 2'b11, 2'b00, 1,   0,  0, 1, 1, 56, 0, 0, 1);

    foreach (tbl[i]) begin
      for (int r = 0; r < tbl[i].rpt; r++) step(tbl[i].g, tbl[i].t, tbl[i].h, tbl[i].m);
      check($sformatf("row%0d.s0", i), score8[7:0], tbl[i].s0);
      check($sformatf("row%0d.s1", i), score8[15:8], tbl[i].s1);
      check($sformatf("row%0d.m0", i), mult8[2:0], tbl[i].m0);
      check($sformatf("row%0d.m1", i), mult8[5:3], tbl[i].m1);
      check($sformatf("row%0d.high", i), hs8, tbl[i].hs);
      check($sformatf("row%0d.new_high", i), nh8, tbl[i].nh);
      check($sformatf("row%0d.leader", i), ld8, tbl[i].ld);
      check($sformatf("row%0d.tie", i), tie8, tbl[i].ti);
      if (i == 22 || i == 23) check($sformatf("row%0d.sat4", i), score4[3:0], 15);
    end

    // 6/6 tie, then a lead change, then asynchronous reset mid-round
    repeat (5) step(1, 0, 2'b11, 2'b00);
    check("tie66.scores", score8, 16'h0606);
    check("tie66.tie", tie8, 1);
    check("tie66.leader", ld8, 0);
    step(1, 0, 2'b10, 2'b00);
    check("lead1.leader", ld8, 1);
    check("lead1.tie", tie8, 0);
    #2;
    reset = 1'b0;
    #1;
    check_reset_vals("async");
    model_reset();
    @(negedge clk);
    reset = 1'b1;

    // randomized: short rounds first, then long rounds that reach saturation
    for (int n = 0; n < 1200; n++) begin
      logic g, t;
      logic [1:0] h, m;
      if (n < 500) begin
        g = ($urandom_range(0, 15) != 0);
        t = ($urandom_range(0, 30) == 0);
      end else begin
        g = ($urandom_range(0, 63) != 0);
        t = ($urandom_range(0, 150) == 0);
      end
      h = 2'($urandom_range(0, 3));
      m = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      step(g, t, h, m);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/score_tracker.md
# score_tracker

Multi-player score tracker for the mole game, parametrised in player count, score width and streak multiplier. Each player's lane accumulates points from single-cycle hit pulses, using a streak-based multiplier that resets on a miss. Final scores are held after the game ends for display. A high-score register persists across games and is cleared only by reset. The block sits between the per-player hit detectors and the display and scoreboard logic, under the game timer's control.

## Interface
Parameters:
- NUM_PLAYERS, 2: number of independent score lanes, ≥ 1.
- SCORE_W, 8: score width; saturates at 2^SCORE_W−1.
- STREAK_LEN, 4: consecutive hits needed per multiplier step, ≥ 1.
- MAX_MULT, 4: multiplier ceiling, ≥ 1.

Ports:
- clkIn  in  1  100 MHz system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- game_active  in  1  level; high while a round runs.
- timer_expired  in  1  single-cycle pulse ending the round.
- hit  in  NUM_PLAYERS  per-player single-cycle valid-hit pulse.
- miss  in  NUM_PLAYERS  per-player single-cycle miss pulse.
- score  out  NUM_PLAYERS*SCORE_W  packed scores; player i at [i*SCORE_W +: SCORE_W].
- mult  out  NUM_PLAYERS*MW  packed current multipliers, MW = $clog2(MAX_MULT+1).
- high_score  out  SCORE_W  best final score since reset.
- new_high  out  1  one-cycle pulse when high_score is raised.
- leader  out  max(1,$clog2(NUM_PLAYERS))  index of the highest current score.
- tie  out  1  more than one player holds the maximum score.

## Operation
The controller FSM has three states.
- IDLE: entered on reset. Hits and misses are ignored.
  - game_active=1 → RUN.
- RUN: hits and misses are accepted.
  - timer_expired=1 or game_active=0 → DONE.
  - Hits and misses arriving on the exit cycle are ignored.
- DONE: scores and mult are frozen for display.
  - game_active=1 && timer_expired=0 → RUN.
- Clearing on round start: on every IDLE/DONE→RUN transition, all scores are cleared to 0, all streaks to 0 and all mult to 1.
  - Hits arriving on the transition cycle are ignored.

Lane arithmetic in RUN, per player:
- A hit adds the pre-hit mult to score, saturating at 2^SCORE_W−1.
- A hit increments streak, saturating at STREAK_LEN*(MAX_MULT−1).
- mult = 1 + streak/STREAK_LEN (integer division).
- A miss clears streak to 0, which returns mult to 1.
- Hit and miss on the same cycle: hit wins and the miss is dropped.

High score:
- On the RUN→DONE transition cycle, take M = max of all scores.
- If M > high_score, high_score ← M and new_high is pulsed on the next cycle.
- Equal scores do not pulse new_high.

Leader and tie:
- Both are combinational from the score registers.
- leader is the lowest index among the players holding the maximum.
- tie = 1 when two or more players hold the maximum, including all-zero with NUM_PLAYERS>1.

## Timing
- Reset values:
  - score = 0, mult = 1, high_score = 0, new_high = 0, FSM state = IDLE.
  - leader = 0, tie = (NUM_PLAYERS>1).
- Hit latency: a hit at edge n is visible on score and mult after edge n.
- leader and tie follow score combinationally, with zero added latency.
- new_high asserts one cycle after the RUN→DONE edge and lasts exactly one cycle.
- Reset asserted mid-round: every register returns to its reset value immediately, asynchronously. The round in progress is lost and high_score is not updated.
- Simultaneous timer_expired and game_active rising while in DONE: the block stays in DONE.
- Back-to-back hits every cycle are supported; there is no throughput limit.

## Structure
- Shared package score_pkg holds:
  - the FSM state enum (IDLE/RUN/DONE);
  - the MW width function;
  - the saturation helper constants.
- Sub-module score_lane, instantiated NUM_PLAYERS times via generate, holds one player's score, streak and mult logic. Its inputs are clkIn, reset, clear, enable, hit and miss.
- The top level contains the FSM, the max/leader reduction, and the high_score and new_high registers.

## Test plan
- Streak multiplier (NUM_PLAYERS=2, STREAK_LEN=4, MAX_MULT=4). Stimulus: round start, then 12 consecutive hits on player 0. Required: score0 = 4·1+4·2+4·3 = 24, mult0 = 4.
- Miss and priority. Stimulus: 5 hits, then a miss, then 1 hit; afterwards a simultaneous hit and miss. Required: score = 4·1+2+1 = 7 and mult = 1 after the miss. The simultaneous hit+miss counts as a hit and the streak keeps growing.
- Saturation (SCORE_W=4). Stimulus: 20 hits. Required: score0 holds at 15 with no wrap.
- High score across rounds. Round 1 ends with scores 9/5: high_score = 9 and new_high pulses for 1 cycle. Round 2 ends with 9/3: no pulse. Round 3 ends with 4/11: high_score = 11 and new_high pulses.
- Boundary cycles. Stimulus: a hit coincident with timer_expired, and a hit coincident with round start. Required: both are ignored, and DONE holds the final scores until the next round clears them.
- Leader, tie and reset. Stimulus: scores 6/6, then reset asserted mid-round. Required: 6/6 gives tie = 1, leader = 0. After reset, all outputs are at their reset values within the same cycle and high_score = 0.
